// File: rtl/snapshot_pkg.sv
// -----------------------------------------------------------------------------
// snapshot_pkg
// Shared types and helpers for the snapshot capture buffer.
//   snap_state_t : capture state machine encoding
//   MODE_*       : capture mode values as latched from the circ input
//   clog2        : ceiling log2 for elaboration-time width arithmetic
// -----------------------------------------------------------------------------
package snapshot_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } snap_state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CIRC    = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/snapshot_bram_ctrl_sdp_ram.sv
// -----------------------------------------------------------------------------
// sdp_ram
// Simple dual-port RAM: one write port, one synchronous read port, read-first.
// Written in the canonical template so synthesis maps it onto block RAM; the
// array is deliberately left without reset.
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i     : read request and address
//   rdata_o          : read data, valid the cycle after re_i, held otherwise
// -----------------------------------------------------------------------------
module sdp_ram
    import snapshot_pkg::*;
#(
    parameter int DW = 64,
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    // Write and read share one edge; the read sees the pre-write contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/snapshot_bram_ctrl.sv
// -----------------------------------------------------------------------------
// snapshot_bram_ctrl
// Capture buffer between a DSP output stage and the register/bus bridge.
// Fabric samples are written into a 2**AW-word RAM under an arm/trigger state
// machine (one-shot or circular pre/post-trigger capture); the CPU reads the
// RAM back in BUS_W-bit lanes, lane 0 being the most significant slice.
//   clk, rst          : clock, asynchronous active-high reset
//   arm, circ, post_cnt : start/restart capture, mode, post-trigger length
//   trig, din, din_vld  : trigger and gapped fabric data
//   busy, done, wrapped, stop_addr : registered capture status
//   bus_rd_en, bus_addr : bus read request (word address = {ram word, lane})
//   bus_rd_data, bus_rd_vld : read response, two cycles after the request
// -----------------------------------------------------------------------------
module snapshot_bram_ctrl
    import snapshot_pkg::*;
#(
    parameter  int DIN_W = 64,
    parameter  int BUS_W = 32,
    parameter  int AW    = 10,
    localparam int R     = clog2(DIN_W / BUS_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              circ,
    input  logic [AW-1:0]     post_cnt,
    input  logic              trig,
    input  logic [DIN_W-1:0]  din,
    input  logic              din_vld,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output logic [AW-1:0]     stop_addr,
    input  logic              bus_rd_en,
    input  logic [AW+R-1:0]   bus_addr,
    output logic [BUS_W-1:0]  bus_rd_data,
    output logic              bus_rd_vld
);

    localparam int DEPTH = 2**AW;
    localparam int LANES = DIN_W / BUS_W;
    localparam int RW    = (R > 0) ? R : 1;

    snap_state_t       state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rem_q, rem_d;
    logic              circ_q, circ_d;
    logic [AW-1:0]     post_q, post_d;
    logic              wrapped_q, wrapped_d;
    logic              busy_q, done_q;
    logic [AW-1:0]     stop_q;
    logic              we_s;

    logic [AW-1:0]     rd_word_s;
    logic [RW-1:0]     lane_s, lane_q;
    logic [DIN_W-1:0]  ram_rd_s;
    logic [BUS_W-1:0]  lane_sel_s, mid_q, data_q;
    logic              vld1_q, vld2_q, vld_q;

    // Next-state, write enable and pointer/counter update.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rem_d     = rem_q;
        circ_d    = circ_q;
        post_d    = post_q;
        wrapped_d = wrapped_q;
        we_s      = 1'b0;
        if (arm) begin
            // Arm wins over everything, trig included, in any state.
            state_d   = S_ARMED;
            wr_ptr_d  = '0;
            rem_d     = '0;
            wrapped_d = 1'b0;
            circ_d    = circ;
            post_d    = post_cnt;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (trig) begin
                        if (circ_q == MODE_ONESHOT) begin
                            rem_d = (AW+1)'(DEPTH);
                        end else begin
                            rem_d = {1'b0, post_q} + (AW+1)'(1);
                        end
                        // The trigger-cycle word already counts toward rem.
                        if (din_vld) begin
                            we_s  = 1'b1;
                            rem_d = rem_d - (AW+1)'(1);
                        end else begin
                            rem_d = rem_d;
                        end
                        if (rem_d == (AW+1)'(0)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_CAPTURE;
                        end
                    end else if (din_vld && (circ_q == MODE_CIRC)) begin
                        we_s = 1'b1;
                    end else begin
                        we_s = 1'b0;
                    end
                end
                S_CAPTURE: begin
                    if (din_vld) begin
                        we_s  = 1'b1;
                        rem_d = rem_q - (AW+1)'(1);
                        if (rem_q == (AW+1)'(1)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_CAPTURE;
                        end
                    end else begin
                        rem_d = rem_q;
                    end
                end
                S_IDLE:  state_d = S_IDLE;
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
            if (we_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                // Only the circular mode reports wrap; one-shot wraps to 0 by design.
                if ((circ_q == MODE_CIRC) && (&wr_ptr_q)) begin
                    wrapped_d = 1'b1;
                end else begin
                    wrapped_d = wrapped_q;
                end
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
        end
    end

    // Capture state and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rem_q     <= '0;
            circ_q    <= MODE_ONESHOT;
            post_q    <= '0;
            wrapped_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stop_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rem_q     <= rem_d;
            circ_q    <= circ_d;
            post_q    <= post_d;
            wrapped_q <= wrapped_d;
            busy_q    <= (state_d == S_ARMED) || (state_d == S_CAPTURE);
            done_q    <= (state_d == S_DONE);
            if (state_d == S_DONE) begin
                stop_q <= wr_ptr_d;
            end
        end
    end

    assign rd_word_s = bus_addr[AW+R-1:R];

    // Lane index from the low bus address bits (a single lane when R is 0).
    always_comb begin
        lane_s = '0;
        if (R > 0) begin
            lane_s = RW'(bus_addr);
        end else begin
            lane_s = '0;
        end
    end

    sdp_ram #(
        .DW (DIN_W),
        .AW (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (we_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .re_i    (bus_rd_en),
        .raddr_i (rd_word_s),
        .rdata_o (ram_rd_s)
    );

    // MSB-first lane mux on the RAM output.
    always_comb begin
        lane_sel_s = ram_rd_s[DIN_W-1 -: BUS_W];
        for (int i = 1; i < LANES; i++) begin
            if (lane_q == RW'(i)) begin
                lane_sel_s = ram_rd_s[DIN_W-1-i*BUS_W -: BUS_W];
            end else begin
                lane_sel_s = lane_sel_s;
            end
        end
    end

    // Read pipeline: RAM read, lane register, output register; data holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
            vld_q  <= 1'b0;
            lane_q <= '0;
            mid_q  <= '0;
            data_q <= '0;
        end else begin
            vld1_q <= bus_rd_en;
            vld2_q <= vld1_q;
            vld_q  <= vld2_q;
            if (bus_rd_en) begin
                lane_q <= lane_s;
            end
            if (vld1_q) begin
                mid_q <= lane_sel_s;
            end
            if (vld2_q) begin
                data_q <= mid_q;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign wrapped     = wrapped_q;
    assign stop_addr   = stop_q;
    assign bus_rd_data = data_q;
    assign bus_rd_vld  = vld_q;

endmodule

// File: doc/snapshot_bram_ctrl.md
# snapshot_bram_ctrl

Parametrised capture buffer that generalises the fabric/bus shared-BRAM block: fabric samples of `DIN_W` bits are written into an internal `2**AW`-word RAM under a trigger/arm state machine, and the CPU bus reads them back as `BUS_W`-bit words. It adds one-shot and circular (pre/post-trigger) capture modes, gapped-valid input, and capture status. It sits between a DSP output stage, such as a PFB or accumulator, and the register/bus bridge. Both sides run on one clock.

## Interface
- `DIN_W`, 64, fabric word width; must be an integer multiple of `BUS_W`.
- `BUS_W`, 32, bus read width.
- `AW`, 10, fabric address width; `DEPTH = 2**AW` words.
- Derived: `R = log2(DIN_W/BUS_W)`; bus address width is `AW+R` (11 at defaults).

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset; asynchronous, active-high.
- `arm` in 1: single-cycle pulse that starts or restarts a capture.
- `circ` in 1: mode, sampled on `arm`; 0 = one-shot, 1 = circular.
- `post_cnt` in AW: words captured after the trigger word in circular mode; sampled on `arm`.
- `trig` in 1: trigger.
- `din` in DIN_W: fabric data.
- `din_vld` in 1: `din` is valid this cycle.
- `busy` out 1: capture in progress (ARMED or CAPTURE state).
- `done` out 1: capture complete; sticky until the next `arm`.
- `wrapped` out 1: circular write pointer has wrapped at least once.
- `stop_addr` out AW: next write address at completion; this is the oldest word when `wrapped`=1.
- `bus_rd_en` in 1: bus read request.
- `bus_addr` in AW+R: bus word address.
- `bus_rd_data` out BUS_W: read data.
- `bus_rd_vld` out 1: `bus_rd_data` is valid.

## Operation
- States are IDLE, ARMED, CAPTURE and DONE; the machine resets to IDLE.
- `arm` in any state:
  - Go to ARMED.
  - Clear `wr_ptr`, `done` and `wrapped`.
  - Latch `circ` and `post_cnt`.
  - Ignore `trig` in the arm cycle.
- ARMED, one-shot: no writes. ARMED, circular: every `din_vld` writes `din` at `wr_ptr`, and `wr_ptr` increments modulo DEPTH. A wrap from DEPTH-1 to 0 sets `wrapped`.
- ARMED with `trig`=1 goes to CAPTURE. On that edge the `rem` counter (AW+1 bits) loads DEPTH in one-shot mode or `post_cnt`+1 in circular mode.
- The trigger-cycle word is written and counted if `din_vld`=1 in that cycle.
- CAPTURE: each `din_vld` writes `din`, increments `wr_ptr` and decrements `rem`. The write that brings `rem` to 0 moves the machine to DONE.
- Combined case: if the trigger-cycle word alone exhausts `rem` (circular mode with `post_cnt`=0), go directly ARMED→DONE.
- DONE: `done`=1, `stop_addr`=`wr_ptr`, no writes, `trig` ignored.
- Assertions of `trig` outside ARMED are ignored.
- Bus reads are legal in every state.
- Bus lane mapping: `bus_addr[AW+R-1:R]` selects the RAM word and `bus_addr[R-1:0]` selects the lane. Lane 0 is `din[DIN_W-1 -: BUS_W]` (MSB-first).
- A read and a write to the same RAM word in the same cycle return the old data (read-first).
- Readout order: from 0 when `wrapped`=0; from `stop_addr` modulo DEPTH when `wrapped`=1.

## Timing
- Reset: `busy`=`done`=`wrapped`=0, `stop_addr`=0, `bus_rd_vld`=0, `bus_rd_data`=0. Reset acts immediately (asynchronous), including mid-capture. RAM contents are not cleared.
- `busy`, `done`, `wrapped` and `stop_addr` are registered. `done` rises the cycle after the clock edge of the final write.
- `arm` sampled at edge *t* gives `busy`=1 from *t*+1; the first write in circular mode can occur at edge *t*+1.
- Bus read latency is 2 cycles: a `bus_rd_en` at edge *t* gives `bus_rd_vld` and data valid after edge *t*+2, at a throughput of 1 read per cycle.
- `bus_rd_vld` is a pipeline of `bus_rd_en`. `bus_rd_data` holds its last value when `bus_rd_vld`=0.

## Structure
- Package `snapshot_pkg`:
  - state enum `snap_state_t`;
  - mode constants `MODE_ONESHOT`/`MODE_CIRC`;
  - function `clog2`.
- Sub-module `sdp_ram`: simple dual-port RAM with one write port and one synchronous read port, read-first, `DIN_W` x `DEPTH`. It must be inferable as block RAM.
- The top level holds the FSM, pointer and counter, the lane mux register, and the valid pipeline.

## Test plan
- **One-shot:** `AW`=4, defaults otherwise. `arm`, then `trig` 3 cycles later with continuous `din_vld` and `din`=i for i=0..15 → `done` one cycle after the 16th write, `wrapped`=0, `stop_addr`=0. Read `bus_addr` 2 → 0; read `bus_addr` 3 → 1 (lower half of word 1).
- **Circular:** `AW`=4, `post_cnt`=5. Feed 40 words with `din`=k, then `trig` with word 40 → last write is word 45, `stop_addr`=14, `wrapped`=1. RAM word 14 = 30 (oldest) and RAM word 13 = 45.
- **post_cnt=0:** `trig`+`din_vld` → `done` the next cycle, exactly one word written after the trigger.
- **Gapped valid:** one-shot with `din_vld` toggling 1/0 → 16 words in 32 cycles; `trig` during CAPTURE is ignored; data matches only the valid samples.
- **Re-arm and reset:** `arm` mid-CAPTURE → `done` stays 0, `wr_ptr` restarts at 0. `rst` mid-capture → all outputs 0 immediately, then IDLE.
- **Bus timing:** back-to-back `bus_rd_en` → `bus_rd_vld` follows 2 cycles later with no gaps. A same-cycle read/write to one word returns the previous contents.
